// File: rtl/tdc_spi_slave.sv
// SPI mode-0 register slave for the TDC: 10 config bytes (0x00-0x09), 13 read-only
// 24-bit measurement words (0x10-0x1C). Define TDC_SPI_SLAVE_AUTOINC_EN to honour command bit7.
module tdc_spi_slave #(
  parameter int SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        meas_we,
  input  logic [3:0]  meas_idx,
  input  logic [23:0] meas_din,
  output logic [7:0]  config1,
  output logic        start_meas,
  output logic        xfer_done,
  output logic [1:0]  fsm_state
);

`ifdef TDC_SPI_SLAVE_AUTOINC_EN
  localparam logic AUTOINC_EN = 1'b1;
`else
  localparam logic AUTOINC_EN = 1'b0;
`endif

  localparam logic [7:0] CFG_RST [10] = '{8'h00, 8'h40, 8'h07, 8'hFF, 8'hFF,
                                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;
  state_t state;

  // Synchronizers reset low so a CS held low through reset never looks like a new falling edge.
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_prev, cs_prev;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  logic [7:0]  cfg  [10];
  logic [23:0] meas [13];
  logic [6:0]  cmd_sr;
  logic [6:0]  rx_sr;
  logic [23:0] tx_sr;
  logic [4:0]  bit_cnt;
  logic [5:0]  addr;
  logic        wr;
  logic        autoinc;
  logic        wr_pend;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  logic        is_wide;
  logic [4:0]  last_bit;
  logic [5:0]  next_addr;
  logic [5:0]  cmd_addr;
  logic [7:0]  rx_byte;

  assign is_wide   = (addr[5:4] == 2'b01);
  assign last_bit  = is_wide ? 5'd23 : 5'd7;
  assign next_addr = addr + {5'd0, autoinc};
  assign cmd_addr  = {cmd_sr[4:0], mosi_s};
  assign rx_byte   = {rx_sr, mosi_s};
  assign config1   = cfg[0];
  assign fsm_state = state;

  // Read data is left-aligned so the shifter always emits from bit 23.
  function automatic logic [23:0] reg_read(input logic [5:0] a);
    logic [23:0] d;
    d = '0;
    if (a < 6'd10)
      d = {cfg[a[3:0]], 16'h0000};
    else if (a >= 6'h10 && a <= 6'h1C)
      d = meas[a[3:0]];
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 10; i++) cfg[i] <= CFG_RST[i];
      for (int i = 0; i < 13; i++) meas[i] <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      wr         <= 1'b0;
      autoinc    <= 1'b0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      spi_miso   <= 1'b0;
      start_meas <= 1'b0;
      xfer_done  <= 1'b0;
    end else begin
      start_meas <= 1'b0;
      xfer_done  <= 1'b0;
      wr_pend    <= 1'b0;
      if (meas_we && meas_idx <= 4'd12) meas[meas_idx] <= meas_din;
      if (wr_pend) begin
        if (wr_addr < 6'd10) cfg[wr_addr[3:0]] <= wr_data;
        start_meas <= (wr_addr == 6'd0) && wr_data[0];
      end
      if (cs_rise) begin
        state     <= IDLE;
        spi_miso  <= 1'b0;
        xfer_done <= (state != IDLE);
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
          end
          CMD: if (sck_rise) begin
            cmd_sr  <= {cmd_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              state   <= DATA;
              bit_cnt <= '0;
              wr      <= cmd_sr[5];
              autoinc <= cmd_sr[6] & AUTOINC_EN;
              addr    <= cmd_addr;
              tx_sr   <= reg_read(cmd_addr);
            end
          end
          DATA: begin
            if (sck_rise) begin
              rx_sr   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == last_bit) begin
                wr_pend <= wr & ~is_wide;
                wr_addr <= addr;
                wr_data <= rx_byte;
                bit_cnt <= '0;
                addr    <= next_addr;
                tx_sr   <= reg_read(next_addr);
              end
            end else if (sck_fall && !wr) begin
              spi_miso <= tx_sr[23];
              tx_sr    <= {tx_sr[22:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_spi_slave.sv
// Bench for tdc_spi_slave: mode-0 SPI master tasks, read bytes scored against an expected queue.
module tb_tdc_spi_slave;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        meas_we;
  logic [3:0]  meas_idx;
  logic [23:0] meas_din;
  logic [7:0]  config1;
  logic        start_meas;
  logic        xfer_done;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  int sm_cnt = 0;
  int xd_cnt = 0;
  logic [7:0] exp_q[$];

  tdc_spi_slave #(.SYNC_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .meas_we(meas_we),
    .meas_idx(meas_idx), .meas_din(meas_din), .config1(config1),
    .start_meas(start_meas), .xfer_done(xfer_done), .fsm_state(fsm_state)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (start_meas) sm_cnt++;
    if (xfer_done) xd_cnt++;
  end

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic spi_read(input string tag, input logic [7:0] cmd, input int n);
    logic [7:0] rx;
    cs_low();
    spi_bits(cmd, 8, rx);
    check({tag, "_cmd_miso"}, {16'h0, rx}, 24'h0);
    for (int b = 0; b < n; b++) begin
      spi_bits(8'h00, 8, rx);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 24'h1, 24'h0);
      else check(tag, {16'h0, rx}, {16'h0, exp_q.pop_front()});
    end
    cs_high();
  endtask

  task automatic spi_write(input string tag, input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    cs_low();
    spi_bits(cmd, 8, rx);
    spi_bits(data, 8, rx);
    check({tag, "_wr_miso"}, {16'h0, rx}, 24'h0);
    cs_high();
  endtask

  task automatic meas_write(input logic [3:0] idx, input logic [23:0] din);
    @(negedge clk);
    meas_we = 1'b1; meas_idx = idx; meas_din = din;
    @(negedge clk);
    meas_we = 1'b0;
  endtask

  initial begin
    logic [7:0] cfg_rst [10] = '{8'h00, 8'h40, 8'h07, 8'hFF, 8'hFF,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rx;
    int sm0, xd0;
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    meas_we = 1'b0; meas_idx = '0; meas_din = '0;
    repeat (5) @(negedge clk);
    check("rst_miso", {23'h0, spi_miso}, 24'h0);
    check("rst_config1", {16'h0, config1}, 24'h0);
    check("rst_start_meas", {23'h0, start_meas}, 24'h0);
    check("rst_xfer_done", {23'h0, xfer_done}, 24'h0);
    check("rst_state", {22'h0, fsm_state}, 24'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // config reset values and unmapped reads
    for (int a = 0; a < 10; a++) begin
      exp_q.push_back(cfg_rst[a]);
      spi_read("cfg_rst_rd", 8'(a), 1);
    end
    exp_q.push_back(8'h00);
    spi_read("unmapped_0a", 8'h0A, 1);
    exp_q.push_back(8'h00);
    spi_read("unmapped_3f", 8'h3F, 1);

    // autoinc command on 0x01 over two data bytes
    exp_q.push_back(8'h40);
`ifdef TDC_SPI_SLAVE_AUTOINC_EN
    exp_q.push_back(8'h07);
`else
    exp_q.push_back(8'h40);
`endif
    spi_read("autoinc_81", 8'h81, 2);

    // write then read back
    xd0 = xd_cnt;
    spi_write("w41", 8'h41, 8'h83);
    check("w41_xfer_done", 24'(xd_cnt - xd0), 24'd1);
    exp_q.push_back(8'h83);
    spi_read("rd_01", 8'h01, 1);
    check("w41_config1", {16'h0, config1}, 24'h0);

    // measurement words
    meas_write(4'd0, 24'h123456);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    spi_read("meas_10", 8'h10, 3);
    meas_write(4'd12, 24'hABCDEF);
    meas_write(4'd13, 24'h777777);
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hEF);
    spi_read("meas_1c", 8'h1C, 3);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    spi_read("meas_1d", 8'h1D, 3);
    exp_q.push_back(8'h00);
    spi_write("w_ro_meas", 8'h50, 8'hFF);
    spi_read("meas_10_ro", 8'h50, 1);

    // start_meas pulse
    sm0 = sm_cnt;
    spi_write("w40_1", 8'h40, 8'h01);
    check("start_pulse", 24'(sm_cnt - sm0), 24'd1);
    check("w40_config1", {16'h0, config1}, 24'h01);

    // address wrap 0x3F -> 0x00
    exp_q.push_back(8'h00);
`ifdef TDC_SPI_SLAVE_AUTOINC_EN
    exp_q.push_back(8'h01);
`else
    exp_q.push_back(8'h00);
`endif
    spi_read("wrap_bf", 8'hBF, 2);

    sm0 = sm_cnt;
    spi_write("w40_0", 8'h40, 8'h00);
    check("no_start_pulse", 24'(sm_cnt - sm0), 24'd0);
    check("w40_0_config1", {16'h0, config1}, 24'h00);

    spi_write("w_unmapped", 8'h4A, 8'h5A);
    exp_q.push_back(8'h00);
    spi_read("unmapped_wr_rd", 8'h0A, 1);

    // partial byte aborted by CS
    xd0 = xd_cnt;
    cs_low();
    spi_bits(8'h42, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    check("partial_xfer_done", 24'(xd_cnt - xd0), 24'd1);
    exp_q.push_back(8'h07);
    spi_read("partial_rd_02", 8'h02, 1);

    // reset in the middle of a measurement read
    spi_write("w43", 8'h43, 8'h55);
    spi_write("w40_pre", 8'h40, 8'h01);
    cs_low();
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 3, rx);
    repeat (H) @(negedge clk);
    check("pre_rst_miso", {23'h0, spi_miso}, 24'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", {23'h0, spi_miso}, 24'h0);
    check("mid_rst_config1", {16'h0, config1}, 24'h00);
    check("mid_rst_state", {22'h0, fsm_state}, 24'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    exp_q.push_back(8'hFF);
    spi_read("post_rst_03", 8'h03, 1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    spi_read("post_rst_10", 8'h10, 3);

    check("sb_drained", 24'(exp_q.size()), 24'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
